// File: rtl/imem_boot_loader_if.sv
// Signal bundle between a boot byte source (master) and imem_boot_loader (slave).
// It carries the load request, the byte stream, the imem write port and core-reset status.
interface imem_boot_loader_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH:0]   word_count;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  s_valid;
    logic [7:0]            s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  cpu_rst_n;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport master (
        output start, word_count, base_addr, s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error, words_loaded
    );

    modport slave (
        input  start, word_count, base_addr, s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes them to imem
// while holding the core in reset, then releases it. Define LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_boot_loader #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_boot_loader_if.slave bus
);
    // state   | meaning
    // IDLE    | after reset, waiting for start
    // RECV    | collecting bytes of the current word (or of the checksum)
    // WRITE   | one-cycle imem write of the assembled word
    // HOLD    | core still in reset, release timer counting down
    // RUN     | core released, load complete
    // ERROR   | bad word_count or checksum, core held in reset
    localparam int BPW = WORD_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW  = $clog2(RELEASE_DELAY + 1);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_HOLD, S_RUN, S_ERROR} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic [ADDR_WIDTH-1:0] r_base_addr;
    logic [BIW-1:0]        r_byte_idx;
    logic [WORD_WIDTH-1:0] r_word;
    logic [WORD_WIDTH-1:0] w_word_next;
    logic [CW-1:0]         r_hold_cnt;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH:0]   r_words_loaded;
    logic                  w_accept;
    logic                  w_hs;
    logic                  w_last_byte;
    logic                  w_last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_sum;
    logic                  r_csum_phase;
`endif

    assign w_last_byte = (r_byte_idx == BIW'(BPW - 1));
    assign w_last_word = ((r_words_loaded + (ADDR_WIDTH + 1)'(1)) == r_word_count);

    // The incoming byte is merged combinationally so the last byte can go straight to mem_wdata.
    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < BPW; i++) begin
            if (r_byte_idx == BIW'(i)) w_word_next[i*8 +: 8] = bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_hs     = 1'b0;
        case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.word_count > MAX_WORDS)  w_next = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
                    else                             w_next = S_RECV;
`else
                    else if (bus.word_count == '0)   w_next = S_HOLD;
                    else                             w_next = S_RECV;
`endif
                end
            end
            S_RECV: begin
                if (bus.s_valid) begin
                    w_hs = 1'b1;
                    if (w_last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                        if (r_csum_phase) w_next = (w_word_next == r_sum) ? S_HOLD : S_ERROR;
                        else              w_next = S_WRITE;
`else
                        w_next = S_WRITE;
`endif
                    end
                end
            end
            S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                w_next = S_RECV;
`else
                w_next = w_last_word ? S_HOLD : S_RECV;
`endif
            end
            S_HOLD:  if (r_hold_cnt == '0) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count   <= '0;
            r_base_addr    <= '0;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_hold_cnt     <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cpu_rst_n    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
        end else begin
            r_busy      <= (w_next == S_RECV) || (w_next == S_WRITE) || (w_next == S_HOLD);
            r_done      <= (w_next == S_RUN);
            r_cpu_rst_n <= (w_next == S_RUN);
            r_error     <= (w_next == S_ERROR);
            r_mem_we    <= (w_next == S_WRITE);
            if (w_accept) begin
                r_word_count   <= bus.word_count;
                r_base_addr    <= bus.base_addr;
                r_words_loaded <= '0;
                r_byte_idx     <= '0;
            end
            if (w_hs) begin
                r_word     <= w_word_next;
                r_byte_idx <= w_last_byte ? '0 : r_byte_idx + BIW'(1);
            end
            if (w_next == S_WRITE) begin
                r_mem_addr  <= r_base_addr + r_words_loaded[ADDR_WIDTH-1:0];
                r_mem_wdata <= w_word_next;
            end
            if (r_state == S_WRITE) r_words_loaded <= r_words_loaded + (ADDR_WIDTH + 1)'(1);
            if (w_next == S_HOLD && r_state != S_HOLD) r_hold_cnt <= CW'(RELEASE_DELAY - 1);
            else if (r_state == S_HOLD)                r_hold_cnt <= r_hold_cnt - CW'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // A zero-length load goes straight to the checksum phase and expects a checksum of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum        <= '0;
            r_csum_phase <= 1'b0;
        end else if (w_accept) begin
            r_sum        <= '0;
            r_csum_phase <= (bus.word_count == '0);
        end else if (r_state == S_WRITE) begin
            r_sum <= r_sum + r_mem_wdata;
            if (w_last_word) r_csum_phase <= 1'b1;
        end
    end
`endif

    assign bus.s_ready      = (r_state == S_RECV);
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.cpu_rst_n    = r_cpu_rst_n;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words_loaded;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised self-checking bench for imem_boot_loader against a byte-stream/write-list model.
// The checksum stream and its expectations follow LOADER_CHECKSUM_EN when it is defined.
module tb_imem_boot_loader;
    localparam int WW  = 32;
    localparam int AW  = 8;
    localparam int RD  = 4;
    localparam int BPW = WW / 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RELEASE_DELAY(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]    dbytes[$];
    logic [AW-1:0] exp_addr[$];
    logic [WW-1:0] exp_data[$];
    logic [AW-1:0] wlog_addr[$];
    logic [WW-1:0] wlog_data[$];
    int            load_id   = 0;
    bit            ld_active = 1'b0;

    int cyc = 0, seen_id = 0, exp_idx = 0, n_written = 0, last_evt = 0;
    bit evt_seen = 1'b0, prev_cpu = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every write is matched against the model's write list in order.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_cpu = 1'b0;
        end else begin
            if (load_id != seen_id) begin
                seen_id   = load_id;
                n_written = 0;
                exp_idx   = 0;
                evt_seen  = 1'b0;
                wlog_addr.delete();
                wlog_data.delete();
            end
            if (ld_active) chk("words_loaded_track", bus.words_loaded, n_written);
            if (bus.mem_we) begin
                if (!ld_active || exp_idx >= exp_addr.size()) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got mem_we=1 addr 0x%0h data 0x%0h, expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    chk("write_addr", bus.mem_addr, exp_addr[exp_idx]);
                    chk("write_data", bus.mem_wdata, exp_data[exp_idx]);
                    exp_idx++;
                end
                wlog_addr.push_back(bus.mem_addr);
                wlog_data.push_back(bus.mem_wdata);
                n_written++;
                last_evt = cyc;
                evt_seen = 1'b1;
            end
            if (ld_active) begin
                if (bus.s_valid && bus.s_ready) begin
                    last_evt = cyc;
                    evt_seen = 1'b1;
                end
                if (bus.cpu_rst_n && !prev_cpu && evt_seen)
                    chk("release_delay", 64'(cyc - last_evt), 64'(RD + 1));
            end
            chk("s_ready_implies_busy", bus.s_ready & ~bus.busy, 0);
            chk("mem_we_implies_busy", bus.mem_we & ~bus.busy, 0);
            chk("cpu_rst_n_vs_done", bus.cpu_rst_n, bus.done);
            chk("error_excludes_busy", bus.error & bus.busy, 0);
            prev_cpu = bus.cpu_rst_n;
        end
    end

    task automatic fill_random(input int n);
        dbytes.delete();
        repeat (n) dbytes.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_words_loaded"}, bus.words_loaded, 0);
        chk({tag, "_cpu_rst_n"}, bus.cpu_rst_n, 0);
    endtask

    // One load: build the expected write list and byte stream from dbytes, then drive it.
    task automatic run_load(input int cnt, input int base, input int pct, input bit bad_csum,
                            input int inj_at, input int stop_at);
        logic [7:0]    sb[$];
        logic [WW-1:0] sum, w;
        bit            was_run, exp_err, injected, hs;
        int            bi, budget;
        exp_addr.delete();
        exp_data.delete();
        sum = '0;
        if (cnt <= (1 << AW)) begin
            for (int k = 0; k < cnt; k++) begin
                w = '0;
                for (int b = 0; b < BPW; b++) begin
                    w = w | (WW'(dbytes[k*BPW+b]) << (8 * b));
                    sb.push_back(dbytes[k*BPW+b]);
                end
                exp_addr.push_back(AW'((base + k) % (1 << AW)));
                exp_data.push_back(w);
                sum = sum + w;
            end
            if (CSUM_EN) begin
                if (bad_csum) sum = sum + 1;
                for (int b = 0; b < BPW; b++) sb.push_back(8'(sum >> (8 * b)));
            end
        end
        exp_err = (cnt > (1 << AW)) || (CSUM_EN && bad_csum);
        was_run = bus.done;

        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.word_count = (AW + 1)'(cnt);
        bus.base_addr  = AW'(base);
        @(posedge clk); #1;
        bus.start = 1'b0;
        load_id++;
        ld_active = 1'b1;
        if (was_run) chk("cpu_rst_n_falls_on_reload", bus.cpu_rst_n, 0);

        bi = 0;
        injected = 1'b0;
        budget = 0;
        while (bi < sb.size() && budget < 5000) begin
            if (stop_at >= 0 && bi >= stop_at) begin
                bus.s_valid = 1'b0;
                bus.start   = 1'b0;
                return;
            end
            bus.start = (bi == inj_at) && !injected;
            if (bus.start) begin
                injected       = 1'b1;
                bus.word_count = (AW + 1)'(5);
                bus.base_addr  = AW'(8'h77);
            end
            bus.s_valid = ($urandom_range(99) < pct);
            bus.s_data  = bus.s_valid ? sb[bi] : 8'($urandom);
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            if (hs) bi++;
            budget++;
        end
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        chk("stream_drained", bi, sb.size());

        budget = 0;
        while (!(bus.done || bus.error) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk); #1;
        chk("load_completes", bus.done || bus.error, 1);
        chk("error_flag", bus.error, exp_err);
        chk("done_flag", bus.done, !exp_err);
        chk("cpu_rst_n_final", bus.cpu_rst_n, !exp_err);
        chk("busy_final", bus.busy, 0);
        chk("words_loaded_final", bus.words_loaded, (cnt > (1 << AW)) ? 0 : cnt);
        chk("write_count", n_written, exp_addr.size());
    endtask

    logic [7:0] pat_a [12] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                               8'h01, 8'h00, 8'h00, 8'h00};

    initial begin
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.base_addr  = '0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Known stream, no gaps; pins the model with literal words.
        dbytes.delete();
        foreach (pat_a[i]) dbytes.push_back(pat_a[i]);
        run_load(3, 'h10, 100, 1'b0, -1, -1);
        chk("A_write_count", wlog_data.size(), 3);
        if (wlog_data.size() == 3) begin
            chk("A_w0_addr", wlog_addr[0], 8'h10);
            chk("A_w0_data", wlog_data[0], 32'h12345678);
            chk("A_w1_addr", wlog_addr[1], 8'h11);
            chk("A_w1_data", wlog_data[1], 32'hDEADBEEF);
            chk("A_w2_addr", wlog_addr[2], 8'h12);
            chk("A_w2_data", wlog_data[2], 32'h00000001);
        end

        // Same stream with random valid gaps.
        run_load(3, 'h10, 35, 1'b0, -1, -1);
        chk("A_gaps_w1_data", wlog_data.size() > 1 ? wlog_data[1] : '0, 32'hDEADBEEF);

        // Address wrap past the top of memory.
        fill_random(12);
        run_load(3, 'hFE, 60, 1'b0, -1, -1);
        chk("wrap_write_count", wlog_addr.size(), 3);
        if (wlog_addr.size() == 3) begin
            chk("wrap_a0", wlog_addr[0], 8'hFE);
            chk("wrap_a1", wlog_addr[1], 8'hFF);
            chk("wrap_a2", wlog_addr[2], 8'h00);
        end
        chk("wrap_words_loaded", bus.words_loaded, 3);

        // Empty load, then an oversized one.
        dbytes.delete();
        run_load(0, 'h33, 100, 1'b0, -1, -1);
        chk("zero_count_no_writes", n_written, 0);
        run_load(257, 'h00, 100, 1'b0, -1, -1);
        repeat (20) @(negedge clk);
        #1;
        chk("oversize_error_held", bus.error, 1);
        chk("oversize_cpu_rst_n_held", bus.cpu_rst_n, 0);

        // start pulse in the middle of RECV must be ignored.
        fill_random(8);
        run_load(2, 'h40, 80, 1'b0, 2, -1);

        // Reload from RUN, good then corrupted checksum.
        fill_random(8);
        run_load(2, 'h50, 70, 1'b0, -1, -1);
        fill_random(8);
        run_load(2, 'h60, 70, 1'b1, -1, -1);

        // Abort after 6 bytes of a 3-word load, then reload cleanly.
        fill_random(12);
        run_load(3, 'h20, 100, 1'b0, -1, 6);
        chk("abort_writes_before_reset", n_written, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        ld_active = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        fill_random(12);
        run_load(3, 'h20, 70, 1'b0, -1, -1);
        chk("restart_first_addr", wlog_addr.size() > 0 ? wlog_addr[0] : 8'hXX, 8'h20);

        for (int t = 0; t < 4; t++) begin
            int cnt_r;
            cnt_r = $urandom_range(6, 1);
            fill_random(cnt_r * BPW);
            run_load(cnt_r, $urandom_range(255), $urandom_range(100, 30), 1'b0, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
